// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The digit count is derived here so every user sizes its BCD bus the same way.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Decimal digits of 2^width-1, which equals ceil(width*log10(2)) for width >= 1.
  function automatic int bcd_digits(input int width);
    int v;
    int n;
    v = (1 << width) - 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v > 0) begin
        v = v / 10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= ADJ_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// state | meaning
// IDLE  | waiting for start; captures bin when start is high
// SHIFT | one correct-and-shift per edge, WIDTH edges in total
// DONE  | result on bcd is new; one cycle, then back to IDLE
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]    cap;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       scratch_adj;
  logic [CW-1:0]       cnt;
  logic [SW+WIDTH-1:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[4*i +: 4]),
      .dout (scratch_adj[4*i +: 4])
    );
  end

  // The corrected MSB digit never exceeds 7, so nothing is lost off the top.
  assign shifted = {scratch_adj, cap} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap     <= bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= shifted[SW+WIDTH-1:WIDTH];
          cap     <= shifted[WIDTH-1:0];
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) bcd <= shifted[SW+WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a timing/arithmetic reference model checked every cycle,
// plus literal checks on the directed scenarios.
module tb_bin2bcd_seq;

  localparam int W = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [W-1:0] bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int vectors = 0;
  int miss    = 0;

  bin2bcd_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: a conversion captured at cycle c is busy for ages 0..W-1,
  // shows done at age W, and is finished after age W.
  int          cyc = 0;
  int          cap_cyc = 0;
  int          m_val = 0;
  logic        m_active = 1'b0;
  logic [11:0] m_bcd = '0;
  logic        chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_bcd    = '0;
    end else begin
      cyc++;
      if (m_active) begin
        if (cyc - cap_cyc == W + 1) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        cap_cyc  = cyc;
        m_val    = int'(bin);
      end
      if (m_active && (cyc - cap_cyc == W)) m_bcd = to_bcd(m_val);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb, ed;
      eb = m_active && ((cyc - cap_cyc) < W);
      ed = m_active && ((cyc - cap_cyc) == W);
      vectors++;
      if (busy !== eb || done !== ed || bcd !== m_bcd) begin
        miss++;
        $display("FAIL model_cycle t=%0t busy=%b exp=%b done=%b exp=%b bcd=%h exp=%h",
                 $time, busy, eb, done, ed, bcd, m_bcd);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One conversion. spur_at >= 0 pulses start with spur_bin at that cycle index,
  // spur_at == -2 throws random extra starts; bin wanders after capture.
  task automatic conv(input logic [W-1:0] v, input int spur_at, input logic [W-1:0] spur_bin,
                      output int busy_cnt, output int done_cnt);
    logic seen;
    busy_cnt = 0;
    done_cnt = 0;
    seen = 1'b0;
    @(posedge clk); #2;
    start = 1'b1;
    bin   = v;
    @(posedge clk); #2;
    start = 1'b0;
    bin   = W'($urandom);
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        seen = 1'b1;
      end
      if (i == spur_at) begin
        start = 1'b1;
        bin   = spur_bin;
      end else if (spur_at == -2 && i < W - 2) begin
        start = ($urandom_range(0, 2) == 0);
        bin   = W'($urandom);
      end else begin
        start = 1'b0;
        bin   = W'($urandom);
      end
      if (seen && i >= W + 2) break;
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    int bc, dc;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bcd", int'(bcd), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    conv(8'd0, -1, '0, bc, dc);
    check("zero_busy_cycles", bc, 8);
    check("zero_done_pulses", dc, 1);
    check("zero_bcd", int'(bcd), 'h000);

    conv(8'd255, -1, '0, bc, dc);
    check("bcd_255", int'(bcd), 'h255);
    conv(8'd99, -1, '0, bc, dc);
    check("bcd_99", int'(bcd), 'h099);
    conv(8'd10, -1, '0, bc, dc);
    check("bcd_10", int'(bcd), 'h010);

    conv(8'd123, 3, 8'd7, bc, dc);
    check("midstart_done_pulses", dc, 1);
    check("midstart_bcd", int'(bcd), 'h123);

    // Reset in the middle of a conversion abandons it.
    @(posedge clk); #2;
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bcd", int'(bcd), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("abort_no_done", dc, 0);
    conv(8'd42, -1, '0, bc, dc);
    check("after_abort_bcd", int'(bcd), 'h042);

    // Start held high with an upstream counter on bin.
    @(posedge clk); #2;
    start = 1'b1;
    bin   = 8'd37;
    dc = 0;
    for (int i = 0; i < 6 * (W + 2); i++) begin
      @(posedge clk); #2;
      bin = bin + 8'd1;
      if (done) dc++;
    end
    start = 1'b0;
    check("stream_done_count", dc, 6);
    repeat (2 * W) @(posedge clk);

    for (int v = 0; v < 256; v++) begin
      conv(W'(v), -2, '0, bc, dc);
      if (dc != 1) check("sweep_done_pulses", dc, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    check("sweep_last_bcd", int'(bcd), 'h255);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
